// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } pctl_state_t;

    // Operand source selection codes shared with the forwarding selector.
    localparam logic [2:0] FWD_RF      = 3'd0;
    localparam logic [2:0] FWD_EXU     = 3'd1;
    localparam logic [2:0] FWD_MEM_ALU = 3'd2;
    localparam logic [2:0] FWD_MEM_LD  = 3'd3;
    localparam logic [2:0] FWD_WB      = 3'd4;

    typedef struct packed {
        logic stall_pc;
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic wb_bubble;
        logic redirect;
    } strobe_t;

    // Freeze every stage register and drain a bubble into WB.
    function automatic strobe_t hold_all();
        strobe_t s;
        s           = '0;
        s.stall_pc  = 1'b1;
        s.stall_if  = 1'b1;
        s.stall_id  = 1'b1;
        s.stall_ex  = 1'b1;
        s.stall_mem = 1'b1;
        s.wb_bubble = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, sticking at the all-ones value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: resolves load-use,
// branch redirect, data-memory wait (with timeout) and fetch wait hazards.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDU_valid,
    input  logic [4:0]       IDU_rs1,
    input  logic [4:0]       IDU_rs2,
    input  logic             IDU_rs1_used,
    input  logic             IDU_rs2_used,
    input  logic             EXU_valid,
    input  logic [4:0]       EXU_rd,
    input  logic             EXU_R_Wen,
    input  logic             EXU_mem_ren,
    input  logic             EXU_br_taken,
    input  logic             MEM_valid,
    input  logic             MEM_mem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             stall_pc,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             wb_bubble,
    output logic             redirect,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    pctl_state_t     state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    strobe_t         st;
    logic            load_use, mem_busy, br;

    assign load_use = IDU_valid & EXU_valid & EXU_mem_ren & EXU_R_Wen & (EXU_rd != 5'd0) &
                      ((IDU_rs1_used & (IDU_rs1 == EXU_rd)) |
                       (IDU_rs2_used & (IDU_rs2 == EXU_rd)));
    assign mem_busy = MEM_valid & MEM_mem_req & ~dmem_ready;
    assign br       = EXU_valid & EXU_br_taken;

    // Prioritised hazard decode; a pending branch is held back while dmem stalls.
    always_comb begin
        st = '0;
        if (state == ST_ERR) begin
            st = hold_all();
        end else if (mem_busy) begin
            st = hold_all();
        end else if (br) begin
            st.redirect = 1'b1;
            st.flush_id = 1'b1;
            st.flush_ex = 1'b1;
        end else if (load_use) begin
            st.stall_pc = 1'b1;
            st.stall_if = 1'b1;
            st.stall_id = 1'b1;
            st.flush_ex = 1'b1;
        end else if (!imem_ready) begin
            st.stall_pc = 1'b1;
            st.stall_if = 1'b1;
            st.flush_id = 1'b1;
        end
    end

    assign stall_pc  = st.stall_pc;
    assign stall_if  = st.stall_if;
    assign stall_id  = st.stall_id;
    assign stall_ex  = st.stall_ex;
    assign stall_mem = st.stall_mem;
    assign flush_id  = st.flush_id;
    assign flush_ex  = st.flush_ex;
    assign wb_bubble = st.wb_bubble;
    assign redirect  = st.redirect;
    assign bus_err   = (state == ST_ERR);

    // Data-memory wait tracking; a vanished request also ends the wait.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = WC_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_busy) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_ERR;
                end else begin
                    wait_nxt = wait_cnt + WC_W'(1);
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (st.stall_pc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (st.redirect),
        .count (flush_cnt)
    );

endmodule
